// File: rtl/adc_dco_phase_cal.sv
// DCO phase calibration: sweeps the 8 delay taps against the ADC checkerboard
// test pattern and parks the delay at the centre of the longest passing run.
module adc_dco_phase_cal #(
    parameter int                DATA_W        = 14,
    parameter logic [DATA_W-1:0] PAT_A         = 14'h2AAA,
    parameter logic [DATA_W-1:0] PAT_B         = 14'h1555,
    parameter int                SETTLE_CYCLES = 16,
    parameter int                CHECK_CYCLES  = 64
) (
    input  logic              in_clk_p,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] adc_data,
    output logic [2:0]        delay,
    output logic              busy,
    output logic              done,
    output logic              cal_ok,
    output logic [7:0]        pass_mask,
    output logic [2:0]        best_delay
);

    typedef enum logic [2:0] {
        IDLE, APPLY, CHECK, RECORD, SCAN, FINAL
    } state_t;

    state_t            state, state_n;
    logic [15:0]       cnt;
    logic [2:0]        idx;
    logic              fail;
    logic [DATA_W-1:0] expect_w;
    logic [2:0]        cur_start, best_start;
    logic [3:0]        cur_len, best_len;

    logic              last_settle, last_check;
    logic              bit_v, take;
    logic [3:0]        run_len_n, bl_n, half;
    logic [2:0]        run_start_n, bs_n, centre;

    assign last_settle = (cnt == 16'(SETTLE_CYCLES - 1));
    assign last_check  = (cnt == 16'(CHECK_CYCLES - 1));

    // One step of the longest-run search over pass_mask, bit idx.
    always_comb begin
        bit_v       = pass_mask[idx];
        run_len_n   = bit_v ? cur_len + 4'd1 : 4'd0;
        run_start_n = (cur_len == 4'd0) ? idx : cur_start;
        take        = bit_v && (run_len_n > best_len);
        bl_n        = take ? run_len_n : best_len;
        bs_n        = take ? run_start_n : best_start;
        half        = (bl_n - 4'd1) >> 1;
        centre      = bs_n + half[2:0];
    end

    // State register.
    always_ff @(posedge in_clk_p) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state logic plus the busy/done status outputs.
    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state)
            IDLE:   if (start) state_n = APPLY;
            APPLY: begin
                busy = 1'b1;
                if (last_settle) state_n = CHECK;
            end
            CHECK: begin
                busy = 1'b1;
                if (last_check) state_n = RECORD;
            end
            RECORD: begin
                busy    = 1'b1;
                state_n = (idx == 3'd7) ? SCAN : APPLY;
            end
            SCAN: begin
                busy = 1'b1;
                if (idx == 3'd7) state_n = FINAL;
            end
            FINAL: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Sweep counters, pattern checker, run search and result registers.
    always_ff @(posedge in_clk_p) begin
        if (reset) begin
            cnt        <= '0;
            idx        <= '0;
            fail       <= 1'b0;
            expect_w   <= '0;
            cur_start  <= '0;
            cur_len    <= '0;
            best_start <= '0;
            best_len   <= '0;
            delay      <= '0;
            cal_ok     <= 1'b0;
            pass_mask  <= '0;
            best_delay <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        pass_mask <= '0;
                        idx       <= '0;
                        cnt       <= '0;
                        fail      <= 1'b0;
                        delay     <= '0;
                    end
                end
                APPLY: begin
                    cnt <= last_settle ? 16'd0 : cnt + 16'd1;
                end
                CHECK: begin
                    cnt <= last_check ? 16'd0 : cnt + 16'd1;
                    if (cnt == 16'd0) begin
                        if (adc_data != PAT_A && adc_data != PAT_B)
                            fail <= 1'b1;
                        expect_w <= (adc_data == PAT_A) ? PAT_B : PAT_A;
                    end else begin
                        if (adc_data != expect_w) fail <= 1'b1;
                        expect_w <= (expect_w == PAT_A) ? PAT_B : PAT_A;
                    end
                end
                RECORD: begin
                    pass_mask[idx] <= ~fail;
                    fail           <= 1'b0;
                    cnt            <= '0;
                    if (idx == 3'd7) begin
                        idx        <= '0;
                        cur_start  <= '0;
                        cur_len    <= '0;
                        best_start <= '0;
                        best_len   <= '0;
                    end else begin
                        idx   <= idx + 3'd1;
                        delay <= idx + 3'd1;
                    end
                end
                SCAN: begin
                    cur_len    <= run_len_n;
                    cur_start  <= run_start_n;
                    best_len   <= bl_n;
                    best_start <= bs_n;
                    idx        <= idx + 3'd1;
                    if (idx == 3'd7) begin
                        best_delay <= (bl_n != 4'd0) ? centre : 3'd0;
                        cal_ok     <= (bl_n != 4'd0);
                    end
                end
                FINAL: begin
                    delay <= best_delay;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_dco_phase_cal.sv
// Bench for adc_dco_phase_cal: per-tap pattern corruption table plus
// hand-written reset-abort and ignored-start sequences.
module tb_adc_dco_phase_cal;

    localparam int S       = 16;
    localparam int C       = 64;
    localparam int WIN     = S + C + 1;
    localparam int DONE_AT = 8 * WIN + 9;

    typedef struct {
        logic [7:0] pass;
        bit         zero;
        logic [7:0] mask;
        logic [2:0] best;
        logic       ok;
    } vec_t;

    typedef struct {
        logic [7:0] mask;
        logic [2:0] best;
        logic       ok;
        int         done_at;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [13:0] adc_data = '0;
    logic [2:0]  delay;
    logic        busy;
    logic        done;
    logic        cal_ok;
    logic [7:0]  pass_mask;
    logic [2:0]  best_delay;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];
    vec_t vecs[8];

    always #5 clk = ~clk;

    adc_dco_phase_cal dut (
        .in_clk_p   (clk),
        .reset      (reset),
        .start      (start),
        .adc_data   (adc_data),
        .delay      (delay),
        .busy       (busy),
        .done       (done),
        .cal_ok     (cal_ok),
        .pass_mask  (pass_mask),
        .best_delay (best_delay)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int flip_pos(input int tap);
        if (tap == 0) return S;
        if (tap == 1) return S + C - 1;
        return S + 10 + tap;
    endfunction

    function automatic logic [13:0] sample(input int k, input logic [7:0] pass,
                                           input bit zero);
        logic [13:0] w;
        int tap, pos;
        w = k[0] ? 14'h2AAA : 14'h1555;
        if (zero) return 14'h0000;
        if (k >= 1 && k <= 8 * WIN) begin
            tap = (k - 1) / WIN;
            pos = (k - 1) % WIN;
            if (!pass[tap] && pos == flip_pos(tap))
                w = w ^ (14'd1 << tap);
        end
        return w;
    endfunction

    task automatic run_cal(input vec_t v, input int extra_start);
        exp_t e, got;
        int done_at;
        e.mask = v.mask;
        e.best = v.best;
        e.ok = v.ok;
        e.done_at = DONE_AT;
        got = e;
        @(negedge clk);
        start = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        done_at = -1;
        for (int k = 1; k <= DONE_AT + 20; k++) begin
            adc_data = sample(k, v.pass, v.zero);
            start = (k == extra_start);
            if (k == 1) begin
                chk("busy_at_t0p1", int'(busy), 1);
                chk("delay_at_t0p1", int'(delay), 0);
            end
            if (done && done_at < 0) begin
                done_at = k;
                got = sb.pop_front();
                chk("done_cycle", done_at, got.done_at);
                chk("busy_at_done", int'(busy), 0);
                chk("pass_mask", int'(pass_mask), int'(got.mask));
                chk("best_delay", int'(best_delay), int'(got.best));
                chk("cal_ok", int'(cal_ok), int'(got.ok));
            end else if (done_at > 0 && k == done_at + 1) begin
                chk("done_width", int'(done), 0);
                chk("busy_after", int'(busy), 0);
                chk("delay_after", int'(delay), int'(got.best));
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        if (done_at < 0) begin
            chk("done_timeout", done_at, DONE_AT);
            void'(sb.pop_front());
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_delay"}, int'(delay), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_cal_ok"}, int'(cal_ok), 0);
        chk({tag, "_pass_mask"}, int'(pass_mask), 0);
        chk({tag, "_best_delay"}, int'(best_delay), 0);
    endtask

    initial begin
        vec_t v;
        int n_done;

        vecs[0] = '{8'hFF, 1'b0, 8'hFF, 3'd3, 1'b1};
        vecs[1] = '{8'h3C, 1'b0, 8'h3C, 3'd3, 1'b1};
        vecs[2] = '{8'hF3, 1'b0, 8'hF3, 3'd5, 1'b1};
        vecs[3] = '{8'h66, 1'b0, 8'h66, 3'd1, 1'b1};
        vecs[4] = '{8'h80, 1'b0, 8'h80, 3'd7, 1'b1};
        vecs[5] = '{8'h00, 1'b1, 8'h00, 3'd0, 1'b0};
        vecs[6] = '{8'hFE, 1'b0, 8'hFE, 3'd4, 1'b1};
        vecs[7] = '{8'h01, 1'b0, 8'h01, 3'd0, 1'b1};

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst0");
        reset = 1'b0;

        for (int i = 0; i < 8; i++) run_cal(vecs[i], 0);

        // Second start while busy must not restart the sweep.
        run_cal(vecs[0], 100);
        // Start in the done cycle is ignored.
        run_cal(vecs[3], DONE_AT);

        // Reset during tap 4 CHECK aborts with no done.
        v = vecs[0];
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k < 350; k++) begin
            adc_data = sample(k, v.pass, v.zero);
            @(posedge clk);
            #1;
        end
        chk("busy_tap4", int'(busy), 1);
        chk("delay_tap4", int'(delay), 4);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_vals("rst_mid");
        reset = 1'b0;
        n_done = 0;
        for (int k = 0; k < DONE_AT + 20; k++) begin
            adc_data = sample(k, v.pass, v.zero);
            if (done) n_done++;
            @(posedge clk);
            #1;
        end
        chk("no_done_after_abort", n_done, 0);
        chk("idle_after_abort", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/adc_dco_phase_cal.md
# adc_dco_phase_cal

Receive-side phase calibration engine for the AD9643 capture path. It sweeps the ADC DCO delay setting (`delay`, 3 bits, 8 taps) and checks, at each tap, whether the captured data matches the ADC alternating checkerboard test pattern. It then finds the longest contiguous run of passing taps, selects the tap at the centre of that run, and drives it onto `delay`. It sits between the ADC data capture registers and the DCO phase-delay control.

## Interface
- `DATA_W`, 14: captured ADC sample width.
- `PAT_A`, 14'h2AAA: checkerboard word A.
- `PAT_B`, 14'h1555: checkerboard word B.
- `SETTLE_CYCLES`, 16: cycles waited after each delay change before checking (≥1).
- `CHECK_CYCLES`, 64: samples compared per tap (≥2).

Ports:
- `in_clk_p` input 1: capture clock; all logic on its rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: calibration request, single-cycle pulse; sampled only in IDLE.
- `adc_data` input DATA_W: captured sample, one per cycle, already in `in_clk_p` domain.
- `delay` output 3: DCO delay tap driven to the phase-adjust stage.
- `busy` output 1: high from the cycle after `start` is accepted until `done`.
- `done` output 1: one-cycle pulse when calibration completes.
- `cal_ok` output 1: last calibration found at least one passing tap.
- `pass_mask` output 8: bit n = tap n passed in the last run.
- `best_delay` output 3: selected tap from the last run.

## Operation
- States: IDLE, APPLY, CHECK, RECORD, SCAN, FINAL.
- IDLE: `start`=1 → clear `pass_mask`, set tap index to 0, go to APPLY. `start` in any other state is ignored.
- APPLY: `delay`=tap index; count SETTLE_CYCLES cycles, then go to CHECK.
- CHECK: runs for CHECK_CYCLES cycles.
  - First sample passes if it equals PAT_A or PAT_B; the expected next word becomes the other pattern.
  - Each following sample must equal the expected word; the expected word toggles every cycle.
  - Any mismatch sets a sticky per-tap fail flag, which is cleared on entry to APPLY.
- RECORD (1 cycle): `pass_mask[idx]` = !fail. If idx==7, go to SCAN; otherwise idx+1 → APPLY.
- SCAN (8 cycles, bit 0 to 7): track the current run start and length, and the best run start and length.
  - Runs do not wrap from 7 to 0.
  - A run replaces the best only if it is strictly longer, so a tie keeps the lowest start.
- FINAL (1 cycle):
  - If best length > 0: `best_delay` = best_start + (best_len−1)/2 (floor), `cal_ok`=1.
  - Otherwise: `best_delay`=0, `cal_ok`=0.
  - Then `done`=1 and go to IDLE.
- In IDLE after a run, `delay` = `best_delay`; this is 0 when `cal_ok`=0.

## Timing
- Reset values: `delay`=0, `busy`=0, `done`=0, `cal_ok`=0, `pass_mask`=0, `best_delay`=0, state IDLE.
- Reset mid-run aborts immediately to the reset values. No `done` is issued.
- `start` sampled at edge T0 → `busy`=1 and `delay`=0 from T0+1.
- Per-tap time = SETTLE_CYCLES + CHECK_CYCLES + 1 cycles. The sweep takes 8× that.
- SCAN takes 8 cycles and FINAL takes 1 cycle. `done` is high for the single cycle T0 + 8·(S+C+1) + 9. With defaults this is T0+657.
- `busy` falls in the same cycle `done` is high. `pass_mask`, `best_delay` and `cal_ok` are valid in that cycle and held until the next accepted `start`.
- `delay` changes only at APPLY entry and at the FINAL→IDLE transition.
- The first CHECK sample is the `adc_data` value present in the first CHECK cycle. No pipeline latency is added internally.
- `start` asserted in the same cycle `done` is high is ignored (state is not IDLE).

## Test plan
- Perfect checkerboard at all taps → `pass_mask`=8'hFF, `best_delay`=3, `cal_ok`=1, `done` at T0+657, `delay`=3 afterwards.
- Model corrupts data (one bit flipped per window) except at taps 2–5 → `pass_mask`=8'h3C, `best_delay`=3.
- Passing taps 0,1,4,5,6,7 → `pass_mask`=8'hF3, longest run 4–7, `best_delay`=5.
- Passing taps 1,2,5,6 (tie) → `pass_mask`=8'h66, `best_delay`=1. Also: only tap 7 passes → `best_delay`=7 (no wrap).
- No tap passes (constant 14'h0000) → `pass_mask`=0, `cal_ok`=0, `best_delay`=0, `delay`=0, `done` still pulses.
- Assert `reset` during tap 4 CHECK → next cycle all outputs are at reset values, with no `done`. A second `start` pulse while `busy` → no restart, and `done` timing is unchanged.
